// File: rtl/mem_hs_ram.sv
// mem_hs_ram: memory responder for the CPU's MFA/MFC handshake.
// Byte-addressed, little-endian word store with word/byte access, a fixed
// number of wait states, and alignment/range error reporting.
// Optional build macro: MEM_HS_WRITE_PROTECT_EN rejects writes below PROTECT_TOP.
module mem_hs_ram #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2,
  parameter int PROTECT_TOP = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MFA,
  input  logic              READ_WRITE,
  input  logic              WORD_BYTE,
  input  logic [ADDR_W-1:0] MEMADD,
  input  logic [31:0]       MEMDAT_IN,
  output logic [31:0]       MEMDAT_OUT,
  output logic              MFC,
  output logic              MEMLOAD,
  output logic              ERR,
  output logic              BUSY
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned BYTES = 4 * DEPTH_WORDS;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_hs_ram: WAIT_CYCLES must be in 0..15 (4-bit wait counter)");
  end
  if (PROTECT_TOP < 0) begin : g_bad_protect
    $error("mem_hs_ram: PROTECT_TOP must not be negative");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              req_rw;
  logic              req_wb;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [31:0]       mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic              misaligned;
  logic              out_of_range;
  logic              prot_hit;
  logic              reject;
  logic              finish;
  logic              commit;

  // Merge write data into the stored word: whole word, or one byte lane only.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_w,
                                             input logic [31:0] din,
                                             input logic        word,
                                             input logic [1:0]  ln);
    logic [31:0] r;
    r = old_w;
    if (word) begin
      r = din;
    end else begin
      case (ln)
        2'd0:    r[7:0]   = din[7:0];
        2'd1:    r[15:8]  = din[7:0];
        2'd2:    r[23:16] = din[7:0];
        default: r[31:24] = din[7:0];
      endcase
    end
    return r;
  endfunction

  // Extract one byte lane (lane 0 = bits [7:0]) zero-extended to 32 bits.
  function automatic logic [31:0] pick_byte(input logic [31:0] w, input logic [1:0] ln);
    logic [7:0] b;
    case (ln)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return {24'b0, b};
  endfunction

  assign idx          = IDX_W'(req_addr >> 2);
  assign lane         = req_addr[1:0];
  assign rd_word      = mem[idx];
  assign misaligned   = req_wb && (req_addr[1:0] != 2'b00);
  assign out_of_range = (32'(req_addr) >= BYTES);
`ifdef MEM_HS_WRITE_PROTECT_EN
  assign prot_hit     = !req_rw && (32'(req_addr) < 32'(PROTECT_TOP));
`else
  assign prot_hit     = 1'b0;
`endif
  assign reject       = misaligned || out_of_range || prot_hit;
  // The WAIT state lasts WAIT_CYCLES+1 edges, so MFC rises at capture edge + 1 + WAIT_CYCLES.
  assign finish       = (state == WAIT) && MFA && (cnt == 4'd0) && !Reset;
  assign commit       = finish && !req_rw && !reject;

  // Request capture: inputs are frozen at the accepting edge.
  always_ff @(posedge Clk) begin
    if ((state == IDLE) && MFA && !Reset) begin
      req_rw   <= READ_WRITE;
      req_wb   <= WORD_BYTE;
      req_addr <= MEMADD;
      req_data <= MEMDAT_IN;
    end
  end

  // Storage write on the edge that enters DONE; contents survive Reset.
  always_ff @(posedge Clk) begin
    if (commit) begin
      mem[idx] <= merge_lane(rd_word, req_data, req_wb, lane);
    end
  end

  // Handshake FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      MFC        <= 1'b0;
      MEMLOAD    <= 1'b0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
      MEMDAT_OUT <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (MFA) begin
            state <= WAIT;
            cnt   <= 4'(WAIT_CYCLES);
            BUSY  <= 1'b1;
          end
        end
        WAIT: begin
          if (!MFA) begin
            state <= IDLE;
            cnt   <= 4'd0;
            BUSY  <= 1'b0;
          end else if (cnt == 4'd0) begin
            state   <= DONE;
            MFC     <= 1'b1;
            ERR     <= reject;
            MEMLOAD <= req_rw && !reject;
            if (reject) begin
              MEMDAT_OUT <= 32'd0;
            end else if (req_rw) begin
              MEMDAT_OUT <= req_wb ? rd_word : pick_byte(rd_word, lane);
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!MFA) begin
            state   <= IDLE;
            MFC     <= 1'b0;
            MEMLOAD <= 1'b0;
            ERR     <= 1'b0;
            BUSY    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_hs_ram.sv
// Directed bench for mem_hs_ram: a default instance (WAIT_CYCLES=2, 64 words)
// and a second instance (WAIT_CYCLES=0, 32 words) share all inputs.
module tb_mem_hs_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mfa = 1'b0;
  logic        rw  = 1'b1;
  logic        wb  = 1'b1;
  logic [7:0]  addr = 8'h00;
  logic [31:0] din  = 32'h0;

  logic [31:0] dout, dout0;
  logic        mfc, mload, err, busy;
  logic        mfc0, mload0, err0, busy0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n;

  mem_hs_ram u_dut (
    .Clk(clk), .Reset(rst), .MFA(mfa), .READ_WRITE(rw), .WORD_BYTE(wb),
    .MEMADD(addr), .MEMDAT_IN(din), .MEMDAT_OUT(dout),
    .MFC(mfc), .MEMLOAD(mload), .ERR(err), .BUSY(busy)
  );

  mem_hs_ram #(.ADDR_W(8), .DEPTH_WORDS(32), .WAIT_CYCLES(0), .PROTECT_TOP(16)) u_dut0 (
    .Clk(clk), .Reset(rst), .MFA(mfa), .READ_WRITE(rw), .WORD_BYTE(wb),
    .MEMADD(addr), .MEMDAT_IN(din), .MEMDAT_OUT(dout0),
    .MFC(mfc0), .MEMLOAD(mload0), .ERR(err0), .BUSY(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and let the capture edge pass.
  task automatic start_req(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
    rw   = r;
    wb   = w;
    addr = a;
    din  = d;
    mfa  = 1'b1;
    step();
  endtask

  // Count edges after the current point until the default instance raises MFC.
  task automatic wait_mfc(output int cnt);
    cnt = 0;
    while (mfc !== 1'b1 && cnt < 20) begin
      step();
      cnt++;
    end
  endtask

  // Drop MFA and confirm return to IDLE on the next edge.
  task automatic end_req(input string tag);
    mfa = 1'b0;
    step();
    chk({tag, " mfc low"}, 32'(mfc), 32'd0);
    chk({tag, " busy low"}, 32'(busy), 32'd0);
  endtask

  // Full access; returns edges from capture to MFC.
  task automatic access(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d,
                        output int lat);
    start_req(r, w, a, d);
    wait_mfc(lat);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst mfc", 32'(mfc), 32'd0);
    chk("rst mload", 32'(mload), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst dout", dout, 32'd0);

    // Word write 0x0000CAFE to 0x20; zero-wait instance answers one edge after capture
    start_req(1'b0, 1'b1, 8'h20, 32'h0000CAFE);
    chk("wr busy", 32'(busy), 32'd1);
    chk("wr0 mfc at N", 32'(mfc0), 32'd0);
    step();
    chk("wr0 mfc at N+1", 32'(mfc0), 32'd1);
    chk("wr mfc at N+1", 32'(mfc), 32'd0);
    wait_mfc(n);
    chk("wr latency", 32'(n + 1), 32'd3);
    chk("wr err", 32'(err), 32'd0);
    chk("wr mload", 32'(mload), 32'd0);
    end_req("wr");

    // Word read 0x20
    access(1'b1, 1'b1, 8'h20, 32'h0, n);
    chk("rd latency", 32'(n), 32'd3);
    chk("rd dout", dout, 32'h0000CAFE);
    chk("rd mload", 32'(mload), 32'd1);
    chk("rd err", 32'(err), 32'd0);
    chk("rd0 dout", dout0, 32'h0000CAFE);
    step();
    chk("rd hold mfc", 32'(mfc), 32'd1);
    end_req("rd");
    chk("rd mload cleared", 32'(mload), 32'd0);
    chk("rd dout holds", dout, 32'h0000CAFE);

    // Byte lanes
    access(1'b0, 1'b1, 8'h24, 32'hCAFE0000, n);
    end_req("bw1");
    access(1'b0, 1'b0, 8'h25, 32'h123456BE, n);
    chk("bytewr mload", 32'(mload), 32'd0);
    end_req("bw2");
    access(1'b1, 1'b1, 8'h24, 32'h0, n);
    chk("lane word", dout, 32'hCAFEBE00);
    end_req("bw3");
    access(1'b1, 1'b0, 8'h27, 32'h0, n);
    chk("lane byte3", dout, 32'h000000CA);
    chk("lane byte3 mload", 32'(mload), 32'd1);
    end_req("bw4");
    access(1'b1, 1'b0, 8'h25, 32'h0, n);
    chk("lane byte1", dout, 32'h000000BE);
    end_req("bw5");

    // Errors
    access(1'b1, 1'b1, 8'h21, 32'h0, n);
    chk("misalign err", 32'(err), 32'd1);
    chk("misalign dout", dout, 32'd0);
    chk("misalign mload", 32'(mload), 32'd0);
    chk("misalign latency", 32'(n), 32'd3);
    end_req("e1");
    chk("err cleared", 32'(err), 32'd0);
    access(1'b1, 1'b1, 8'hFC, 32'h0, n);
    chk("0xFC in range 64w err", 32'(err), 32'd0);
    chk("0xFC in range 64w mload", 32'(mload), 32'd1);
    chk("0xFC out of range 32w err", 32'(err0), 32'd1);
    chk("0xFC out of range 32w dout", dout0, 32'd0);
    end_req("e2");
    access(1'b0, 1'b1, 8'h22, 32'hDEADBEEF, n);
    chk("misalign wr err", 32'(err), 32'd1);
    end_req("e3");
    access(1'b1, 1'b1, 8'h20, 32'h0, n);
    chk("after errors 0x20", dout, 32'h0000CAFE);
    chk("after errors 0x20 w0", dout0, 32'h0000CAFE);
    end_req("e4");

    // Handshake abort
    access(1'b0, 1'b1, 8'h30, 32'h11111111, n);
    end_req("ab0");
    start_req(1'b0, 1'b1, 8'h30, 32'h12345678);
    mfa = 1'b0;
    step();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort mfc", 32'(mfc), 32'd0);
    chk("abort0 mfc", 32'(mfc0), 32'd0);
    step();
    step();
    step();
    chk("abort mfc later", 32'(mfc), 32'd0);
    access(1'b1, 1'b1, 8'h30, 32'h0, n);
    chk("abort old value", dout, 32'h11111111);
    chk("abort0 old value", dout0, 32'h11111111);
    end_req("ab1");

    // Reset during WAIT
    start_req(1'b1, 1'b1, 8'h20, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("rstwait mfc", 32'(mfc), 32'd0);
    chk("rstwait busy", 32'(busy), 32'd0);
    chk("rstwait dout", dout, 32'd0);
    chk("rstwait0 dout", dout0, 32'd0);
    rst = 1'b0;
    mfa = 1'b0;
    step();

    // Reset during DONE, with MFA still high across the reset
    access(1'b0, 1'b1, 8'h34, 32'h55AA55AA, n);
    chk("rstdone wr latency", 32'(n), 32'd3);
    rst = 1'b1;
    step();
    chk("rstdone mfc", 32'(mfc), 32'd0);
    chk("rstdone busy", 32'(busy), 32'd0);
    step();
    chk("reset beats mfa", 32'(busy), 32'd0);
    rst = 1'b0;
    access(1'b1, 1'b1, 8'h34, 32'h0, n);
    chk("after reset latency", 32'(n), 32'd3);
    chk("committed write kept", dout, 32'h55AA55AA);
    end_req("rd34");

    // Write protect boundary
    access(1'b0, 1'b1, 8'h04, 32'hFFFFFFFF, n);
`ifdef MEM_HS_WRITE_PROTECT_EN
    chk("prot 0x04 err", 32'(err), 32'd1);
`else
    chk("prot 0x04 err", 32'(err), 32'd0);
`endif
    end_req("p1");
    access(1'b0, 1'b1, 8'h10, 32'hFFFFFFFF, n);
    chk("prot 0x10 err", 32'(err), 32'd0);
    end_req("p2");
    access(1'b1, 1'b1, 8'h10, 32'h0, n);
    chk("prot 0x10 read", dout, 32'hFFFFFFFF);
    chk("prot 0x10 read err", 32'(err), 32'd0);
    end_req("p3");
`ifndef MEM_HS_WRITE_PROTECT_EN
    access(1'b1, 1'b1, 8'h04, 32'h0, n);
    chk("prot 0x04 read", dout, 32'hFFFFFFFF);
    end_req("p4");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
